// File: rtl/reg_wb_stage.sv
// Writeback stage: load extraction, 2-entry skid FIFO, x0 suppression, head forwarding; WB_RETIRE_CNT_EN adds a retire counter.
// Latency: accept at edge N -> RegWrite in cycle N..N+1 if empty/unstalled; mem_ready drops while 2 entries are buffered.
module reg_wb_stage #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              sys_clk,
  input  logic              rst,
  input  logic              mem_valid,
  output logic              mem_ready,
  input  logic [ADDR_W-1:0] mem_rd_addr,
  input  logic [DATA_W-1:0] mem_alu_result,
  input  logic [DATA_W-1:0] mem_load_data,
  input  logic              mem_is_load,
  input  logic [2:0]        mem_funct3,
  input  logic              mem_reg_write,
  input  logic              flush,
  input  logic              wb_stall,
  output logic [ADDR_W-1:0] WriteAddr,
  output logic [DATA_W-1:0] WriteData,
  output logic              RegWrite,
  output logic              fwd_valid,
  output logic [ADDR_W-1:0] fwd_addr,
  output logic [DATA_W-1:0] fwd_data,
  output logic              load_err,
  output logic [31:0]       retire_cnt
);

  typedef struct packed {
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] data;
    logic              we;
  } wbEntry_t;

  wbEntry_t    fifoMem [2];
  logic        wrPtr;
  logic        rdPtr;
  logic [1:0]  count;
  logic        loadErrQ;

  logic [1:0]        off;
  logic [7:0]        byteSel;
  logic [15:0]       halfSel;
  logic [DATA_W-1:0] extracted;
  logic              loadBad;
  logic              accept;
  logic              pop;
  logic              headValid;
  wbEntry_t          head;
  wbEntry_t          newEntry;

  assign mem_ready = (count != 2'd2);
  assign accept    = mem_valid && mem_ready && !flush;
  assign headValid = (count != 2'd0);
  assign head      = fifoMem[rdPtr];
  assign pop       = headValid && !wb_stall && !flush;

  // Little-endian lane select from the byte offset of the load address
  always_comb begin
    off       = mem_alu_result[1:0];
    byteSel   = mem_load_data[{off, 3'b000} +: 8];
    halfSel   = off[1] ? mem_load_data[31:16] : mem_load_data[15:0];
    extracted = '0;
    case (mem_funct3)
      3'b000:  extracted = {{(DATA_W-8){byteSel[7]}}, byteSel};
      3'b001:  extracted = {{(DATA_W-16){halfSel[15]}}, halfSel};
      3'b010:  extracted = mem_load_data;
      3'b100:  extracted = {{(DATA_W-8){1'b0}}, byteSel};
      3'b101:  extracted = {{(DATA_W-16){1'b0}}, halfSel};
      default: extracted = '0;
    endcase
  end

  always_comb begin
    loadBad = 1'b0;
    if (mem_is_load) begin
      case (mem_funct3)
        3'b011, 3'b110, 3'b111: loadBad = 1'b1;
        3'b001, 3'b101:         loadBad = off[0];
        3'b010:                 loadBad = (off != 2'b00);
        default:                loadBad = 1'b0;
      endcase
    end
  end

  // A bad load still occupies a slot so it retires in order, just without writing
  always_comb begin
    newEntry.rd   = mem_rd_addr;
    newEntry.data = mem_is_load ? extracted : mem_alu_result;
    newEntry.we   = mem_reg_write && !loadBad;
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      count      <= 2'd0;
      wrPtr      <= 1'b0;
      rdPtr      <= 1'b0;
      loadErrQ   <= 1'b0;
      fifoMem[0] <= '0;
      fifoMem[1] <= '0;
    end else begin
      loadErrQ <= accept && loadBad;
      if (flush) begin
        count <= 2'd0;
        wrPtr <= 1'b0;
        rdPtr <= 1'b0;
      end else begin
        if (accept) begin
          fifoMem[wrPtr] <= newEntry;
          wrPtr          <= ~wrPtr;
        end
        if (pop) rdPtr <= ~rdPtr;
        count <= count + {1'b0, accept} - {1'b0, pop};
      end
    end
  end

  always_comb begin
    WriteAddr = headValid ? head.rd : '0;
    WriteData = headValid ? head.data : '0;
    fwd_valid = headValid && head.we && (head.rd != '0);
    fwd_addr  = WriteAddr;
    fwd_data  = WriteData;
    RegWrite  = fwd_valid && !wb_stall && !flush && !rst;
    load_err  = loadErrQ;
  end

`ifdef WB_RETIRE_CNT_EN
  logic [31:0] retireCntQ;

  // Counts every popped entry, including x0 and errored ones; survives flush
  always_ff @(posedge sys_clk) begin
    if (rst)      retireCntQ <= 32'd0;
    else if (pop) retireCntQ <= retireCntQ + 32'd1;
  end

  assign retire_cnt = retireCntQ;
`else
  assign retire_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_reg_wb_stage.sv
// Scoreboarded bench for reg_wb_stage: stimulus pushes expected RegFile writes, a negedge monitor pops and compares.
module tb_reg_wb_stage;

  logic        sys_clk = 1'b0;
  logic        rst, mem_valid, mem_ready, mem_is_load, mem_reg_write, flush, wb_stall;
  logic [4:0]  mem_rd_addr, WriteAddr, fwd_addr;
  logic [31:0] mem_alu_result, mem_load_data, WriteData, fwd_data, retire_cnt;
  logic [2:0]  mem_funct3;
  logic        RegWrite, fwd_valid, load_err;

  int passCnt  = 0;
  int totalCnt = 0;
  logic [36:0] expQ [$];

  always #5 sys_clk = ~sys_clk;

  reg_wb_stage dut (
    .sys_clk(sys_clk), .rst(rst), .mem_valid(mem_valid), .mem_ready(mem_ready),
    .mem_rd_addr(mem_rd_addr), .mem_alu_result(mem_alu_result), .mem_load_data(mem_load_data),
    .mem_is_load(mem_is_load), .mem_funct3(mem_funct3), .mem_reg_write(mem_reg_write),
    .flush(flush), .wb_stall(wb_stall), .WriteAddr(WriteAddr), .WriteData(WriteData),
    .RegWrite(RegWrite), .fwd_valid(fwd_valid), .fwd_addr(fwd_addr), .fwd_data(fwd_data),
    .load_err(load_err), .retire_cnt(retire_cnt)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    totalCnt++;
    if (act === exp) passCnt++;
    else $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
  endtask

  // Scoreboard monitor: every RegFile write must match the oldest expected write
  always @(negedge sys_clk) begin
    if (RegWrite === 1'b1) begin
      if (expQ.size() == 0) begin
        chk("unexpected write addr", {27'd0, WriteAddr}, 32'hFFFF_FFFF);
      end else begin
        logic [36:0] e;
        e = expQ.pop_front();
        chk("wb addr", {27'd0, WriteAddr}, {27'd0, e[36:32]});
        chk("wb data", WriteData, e[31:0]);
      end
    end
  end

  task automatic drive(input logic [4:0] rd, input logic [31:0] alu, input logic [31:0] ld,
                       input logic isLoad, input logic [2:0] f3);
    mem_valid      = 1'b1;
    mem_rd_addr    = rd;
    mem_alu_result = alu;
    mem_load_data  = ld;
    mem_is_load    = isLoad;
    mem_funct3     = f3;
    mem_reg_write  = 1'b1;
  endtask

  // Single transaction; returns just after its accept edge
  task automatic issue(input logic [4:0] rd, input logic [31:0] alu, input logic [31:0] ld,
                       input logic isLoad, input logic [2:0] f3, input logic expWrite,
                       input logic [31:0] expData);
    int budget;
    @(posedge sys_clk); #1;
    drive(rd, alu, ld, isLoad, f3);
    if (expWrite) expQ.push_back({rd, expData});
    budget = 0;
    forever begin
      @(negedge sys_clk);
      if (mem_ready === 1'b1) break;
      budget++;
      if (budget > 50) begin
        chk("mem_ready timeout", {31'd0, mem_ready}, 32'd1);
        break;
      end
    end
    @(posedge sys_clk); #1;
    mem_valid = 1'b0;
  endtask

  task automatic fillTwoUnderStall();
    @(posedge sys_clk); #1;
    wb_stall = 1'b1;
    drive(5'd20, 32'h20, 32'h0, 1'b0, 3'b010);
    @(posedge sys_clk); #1;
    drive(5'd21, 32'h21, 32'h0, 1'b0, 3'b010);
    @(posedge sys_clk); #1;
    mem_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; mem_valid = 1'b0; mem_rd_addr = '0; mem_alu_result = '0; mem_load_data = '0;
    mem_is_load = 1'b0; mem_funct3 = '0; mem_reg_write = 1'b0; flush = 1'b0; wb_stall = 1'b0;
    repeat (2) @(posedge sys_clk);
    @(negedge sys_clk);
    chk("rst mem_ready", {31'd0, mem_ready}, 32'd1);
    chk("rst RegWrite", {31'd0, RegWrite}, 32'd0);
    chk("rst WriteAddr", {27'd0, WriteAddr}, 32'd0);
    chk("rst WriteData", WriteData, 32'd0);
    chk("rst fwd_valid", {31'd0, fwd_valid}, 32'd0);
    chk("rst load_err", {31'd0, load_err}, 32'd0);
    chk("rst retire_cnt", retire_cnt, 32'd0);
    @(posedge sys_clk); #1;
    rst = 1'b0;

    // LW: write visible the cycle after accept
    issue(5'd5, 32'h100, 32'hDEADBEEF, 1'b1, 3'b010, 1'b1, 32'hDEADBEEF);
    @(negedge sys_clk);
    chk("lw RegWrite", {31'd0, RegWrite}, 32'd1);
    chk("lw fwd_data", fwd_data, 32'hDEADBEEF);
    chk("lw load_err", {31'd0, load_err}, 32'd0);
    @(negedge sys_clk);
`ifdef WB_RETIRE_CNT_EN
    chk("retire_cnt after lw", retire_cnt, 32'd1);
`else
    chk("retire_cnt tied", retire_cnt, 32'd0);
`endif

    // Extraction table
    issue(5'd1, 32'h203, 32'h80FF7F01, 1'b1, 3'b000, 1'b1, 32'hFFFFFF80);
    issue(5'd2, 32'h303, 32'h80FF7F01, 1'b1, 3'b100, 1'b1, 32'h00000080);
    issue(5'd3, 32'h402, 32'h80FF7F01, 1'b1, 3'b001, 1'b1, 32'hFFFF80FF);
    issue(5'd4, 32'h500, 32'h80FF7F01, 1'b1, 3'b101, 1'b1, 32'h00007F01);

    // x0 destination never writes
    issue(5'd0, 32'h1234, 32'h0, 1'b0, 3'b000, 1'b0, 32'h0);
    @(negedge sys_clk);
    chk("x0 fwd_valid", {31'd0, fwd_valid}, 32'd0);

    // Misaligned LW and illegal funct3
    issue(5'd7, 32'h102, 32'hCAFEF00D, 1'b1, 3'b010, 1'b0, 32'h0);
    @(negedge sys_clk);
    chk("lw off2 load_err", {31'd0, load_err}, 32'd1);
    @(negedge sys_clk);
    chk("load_err one pulse", {31'd0, load_err}, 32'd0);
    issue(5'd8, 32'h100, 32'hCAFEF00D, 1'b1, 3'b011, 1'b0, 32'h0);
    @(negedge sys_clk);
    chk("f3=011 load_err", {31'd0, load_err}, 32'd1);

    // Stall with three back-to-back valids
    @(posedge sys_clk); #1;
    wb_stall = 1'b1;
    drive(5'd10, 32'hA, 32'h0, 1'b0, 3'b010); expQ.push_back({5'd10, 32'hA});
    @(posedge sys_clk); #1;
    drive(5'd11, 32'hB, 32'h0, 1'b0, 3'b010); expQ.push_back({5'd11, 32'hB});
    @(posedge sys_clk); #1;
    drive(5'd12, 32'hC, 32'h0, 1'b0, 3'b010); expQ.push_back({5'd12, 32'hC});
    @(negedge sys_clk);
    chk("stall mem_ready", {31'd0, mem_ready}, 32'd0);
    chk("stall fwd_valid", {31'd0, fwd_valid}, 32'd1);
    chk("stall fwd_addr", {27'd0, fwd_addr}, 32'd10);
    @(posedge sys_clk); #1;
    wb_stall = 1'b0;
    @(negedge sys_clk);
    chk("release A RegWrite", {31'd0, RegWrite}, 32'd1);
    chk("release A addr", {27'd0, WriteAddr}, 32'd10);
    chk("release A mem_ready", {31'd0, mem_ready}, 32'd0);
    @(negedge sys_clk);
    chk("release B RegWrite", {31'd0, RegWrite}, 32'd1);
    chk("release B addr", {27'd0, WriteAddr}, 32'd11);
    chk("release B mem_ready", {31'd0, mem_ready}, 32'd1);
    @(posedge sys_clk); #1;
    mem_valid = 1'b0;
    @(negedge sys_clk);
    chk("third accepted addr", {27'd0, WriteAddr}, 32'd12);

    // Flush discards both buffered entries
    fillTwoUnderStall();
    @(negedge sys_clk);
    chk("pre-flush mem_ready", {31'd0, mem_ready}, 32'd0);
    @(posedge sys_clk); #1;
    flush = 1'b1;
    @(negedge sys_clk);
    chk("flush RegWrite", {31'd0, RegWrite}, 32'd0);
    @(posedge sys_clk); #1;
    flush = 1'b0;
    @(negedge sys_clk);
    chk("post-flush fwd_valid", {31'd0, fwd_valid}, 32'd0);
    chk("post-flush mem_ready", {31'd0, mem_ready}, 32'd1);
    @(posedge sys_clk); #1;
    wb_stall = 1'b0;
    repeat (2) @(negedge sys_clk);

    // Reset mid-operation with a pending valid
    fillTwoUnderStall();
    drive(5'd25, 32'h25, 32'h0, 1'b0, 3'b010);
    @(posedge sys_clk); #1;
    rst = 1'b1;
    @(negedge sys_clk);
    chk("in-rst RegWrite", {31'd0, RegWrite}, 32'd0);
    @(posedge sys_clk); #1;
    rst = 1'b0;
    wb_stall = 1'b0;
    expQ.push_back({5'd25, 32'h25});
    @(negedge sys_clk);
    chk("post-rst WriteAddr", {27'd0, WriteAddr}, 32'd0);
    chk("post-rst WriteData", WriteData, 32'd0);
    chk("post-rst fwd_valid", {31'd0, fwd_valid}, 32'd0);
    chk("post-rst mem_ready", {31'd0, mem_ready}, 32'd1);
    chk("post-rst retire_cnt", retire_cnt, 32'd0);
    @(posedge sys_clk); #1;
    mem_valid = 1'b0;
    @(negedge sys_clk);
    chk("resume RegWrite", {31'd0, RegWrite}, 32'd1);
    chk("resume addr", {27'd0, WriteAddr}, 32'd25);

    repeat (3) @(negedge sys_clk);
    chk("scoreboard drained", expQ.size(), 32'd0);
    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
